modmod_addsub_serial: RTL and testbench

- Limb-serial modular adder/subtractor for the ECC field arithmetic path.
- Computes (a + b) mod p or (a − b) mod p over W-bit operands, processing one D-bit limb per clock.
- Carry and borrow chains are held in registers between cycles.
- Uses a valid/ready handshake on input and output, so it slots between the operand register file and the point-arithmetic sequencer.
- Generalises the plain W-bit borrow subtractor to a parametrised width, a selectable add/sub mode and a built-in modular correction.

---
 rtl/modmod_addsub_serial.sv | 136 +++++++++++++
 tb/tb_modmod_addsub_serial.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/modmod_addsub_serial.sv
// Limb-serial modular adder/subtractor: (a + b) mod p or (a - b) mod p.
// One D-bit limb per clock, LSB limb first. Two chains run side by side:
// the primary chain computes the raw sum/difference S, and the secondary
// chain computes the corrected value T (S - p for add, S + p for sub). The
// final chain flags pick S or T when the result register is loaded.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand handshake
// CALC  | one limb per cycle for N cycles, both chains advancing
// DONE  | result/out_valid held until the consumer takes them
module modmod_addsub_serial #(
    parameter int W = 256,
    parameter int D = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_r, b_r, p_r, s_r, t_r, result_r;
    logic           op_r, c_r, bw_r;
    logic [CW-1:0]  cnt;

    logic [D-1:0]   a_k, b_k, p_k, s_k, t_k;
    logic [D:0]     prim, sec;
    logic           c_nx, bw_nx, sel_nx, last;
    logic [W-1:0]   s_full, t_full;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign last      = (cnt == CW'(N - 1));

    // Limb arithmetic for the current counter position. The D+1 bit
    // intermediates carry the chain-out bit in their MSB; for a difference
    // that MSB is set exactly when the true value went negative.
    always_comb begin
        a_k    = a_r[cnt*D +: D];
        b_k    = b_r[cnt*D +: D];
        p_k    = p_r[cnt*D +: D];
        prim   = '0;
        sec    = '0;
        c_nx   = c_r;
        bw_nx  = bw_r;
        sel_nx = 1'b0;
        if (!op_r) begin
            prim   = {1'b0, a_k} + {1'b0, b_k} + {{D{1'b0}}, c_r};
            sec    = {1'b0, prim[D-1:0]} - {1'b0, p_k} - {{D{1'b0}}, bw_r};
            c_nx   = prim[D];
            bw_nx  = sec[D];
            // sum >= p when the raw sum overflowed W bits or S - p did not borrow
            sel_nx = prim[D] | ~sec[D];
        end else begin
            prim   = {1'b0, a_k} - {1'b0, b_k} - {{D{1'b0}}, bw_r};
            sec    = {1'b0, prim[D-1:0]} + {1'b0, p_k} + {{D{1'b0}}, c_r};
            bw_nx  = prim[D];
            c_nx   = sec[D];
            // a < b: wrap back into range by adding p
            sel_nx = prim[D];
        end
        s_k    = prim[D-1:0];
        t_k    = sec[D-1:0];
        s_full = s_r;
        t_full = t_r;
        s_full[cnt*D +: D] = s_k;
        t_full[cnt*D +: D] = t_k;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; in_valid only matters in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Operand capture, limb-serial accumulation and result load. The result
    // is loaded on the final limb from the merged S/T images so out_valid
    // and result appear together on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            c_r      <= 1'b0;
            bw_r     <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        p_r  <= p;
                        op_r <= op;
                        cnt  <= '0;
                        c_r  <= 1'b0;
                        bw_r <= 1'b0;
                    end
                end
                CALC: begin
                    s_r  <= s_full;
                    t_r  <= t_full;
                    c_r  <= c_nx;
                    bw_r <= bw_nx;
                    if (last) result_r <= sel_nx ? t_full : s_full;
                    else      cnt      <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modmod_addsub_serial.sv
module tb_modmod_addsub_serial;

    localparam logic [255:0] PK = {{6{32'hFFFFFFFF}}, 32'hFFFFFFFE, 32'hFFFFFC2F};
    localparam logic [255:0] P97 = 256'd97;

    logic         clk = 1'b0;
    logic         rst;

    logic         in_valid, in_ready, op, out_valid, out_ready;
    logic [255:0] a, b, p, result;

    logic         in_valid1, in_ready1, op1, out_valid1, out_ready1;
    logic [63:0]  a1, b1, p1, result1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    modmod_addsub_serial #(.W(256), .D(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .p(p), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    modmod_addsub_serial #(.W(64), .D(64)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
        .a(a1), .b(b1), .p(p1), .out_valid(out_valid1), .out_ready(out_ready1), .result(result1)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the mathematical definition.
    function automatic logic [255:0] ref_mod(input bit o, input logic [255:0] x,
                                             input logic [255:0] y, input logic [255:0] m);
        logic [256:0] t;
        if (!o) begin
            t = {1'b0, x} + {1'b0, y};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else begin
            if (x >= y) t = {1'b0, x} - {1'b0, y};
            else        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
        end
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand_below_pk();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        if (x >= PK) x = x - PK;
        return x;
    endfunction

    // One W=256 operation; hold = cycles out_ready stays low after out_valid.
    task automatic run256(input bit o, input logic [255:0] x, input logic [255:0] y,
                          input int hold, input string tag);
        logic [255:0] exp;
        int  lat;
        bit  rdy_bad, hold_bad;
        exp = ref_mod(o, x, y, PK);
        chk({tag, "_in_ready_idle"}, {255'b0, in_ready}, 256'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 0; rdy_bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'd4);
        chk({tag, "_in_ready_busy"}, {255'b0, rdy_bad}, 256'd0);
        chk({tag, "_result"}, result, exp);
        hold_bad = 1'b0;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rand_below_pk(); b = rand_below_pk();
            @(negedge clk);
            if (!out_valid || result !== exp || in_ready) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) chk({tag, "_held"}, {255'b0, hold_bad}, 256'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {255'b0, out_valid}, 256'd0);
        chk({tag, "_ready_back"}, {255'b0, in_ready}, 256'd1);
    endtask

    // One N=1 operation with out_ready tied high; in_valid is left asserted.
    task automatic run97(input bit o, input logic [63:0] x, input logic [63:0] y,
                         input string tag);
        logic [255:0] exp;
        int lat, w;
        exp = ref_mod(o, {192'b0, x}, {192'b0, y}, P97);
        op1 = o; a1 = x; b1 = y; in_valid1 = 1'b1;
        w = 0;
        while (!in_ready1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'd1);
        chk({tag, "_result"}, {192'b0, result1}, exp);
    endtask

    initial begin
        int  lat;
        bit  ov_seen;
        rst = 1'b1;
        in_valid = 1'b0; op = 1'b0; a = '0; b = '0; p = PK; out_ready = 1'b0;
        in_valid1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0; p1 = 64'd97; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_result", result, 256'd0);
        chk("rst1_in_ready", {255'b0, in_ready1}, 256'd1);

        run256(1'b0, PK - 256'd1, 256'd1, 0, "add_pm1_1");
        run256(1'b0, PK - 256'd1, PK - 256'd1, 0, "add_pm1_pm1");
        run256(1'b0, 256'd2, 256'd3, 0, "add_2_3");
        run256(1'b1, 256'd5, 256'd5, 0, "sub_5_5");
        run256(1'b1, 256'd0, 256'd1, 0, "sub_0_1");
        run256(1'b0, 256'd123, PK - 256'd7, 10, "backpressure");

        // Abort while limb 2 is being processed.
        op = 1'b0; a = 256'd11; b = 256'd22; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 1'b0;
        lat = 0;
        repeat (8) begin
            if (out_valid) ov_seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_out_valid", {255'b0, ov_seen}, 256'd0);
        chk("abort_in_ready", {255'b0, in_ready}, 256'd1);
        run256(1'b1, 256'd7, 256'd9, 0, "sub_7_9_after_rst");

        for (int i = 0; i < 16; i++)
            run256(1'($urandom_range(0, 1)), rand_below_pk(), rand_below_pk(),
                   int'($urandom_range(0, 2)), $sformatf("rnd256_%0d", i));

        run97(1'b0, 64'd96, 64'd1, "n1_add_96_1");
        run97(1'b1, 64'd3, 64'd4, "n1_sub_3_4");
        for (int i = 0; i < 12; i++)
            run97(1'($urandom_range(0, 1)), 64'($urandom_range(0, 96)),
                  64'($urandom_range(0, 96)), $sformatf("rnd97_%0d", i));
        in_valid1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
